// File: rtl/reg_scoreboard_if.sv
// Issue/commit/hazard signal bundle between the ID/WB pipeline stages and
// the register-pending scoreboard.
interface reg_scoreboard_if;
   logic [3:0]  src1;
   logic [3:0]  src2;
   logic        two_src;
   logic        issue_valid;
   logic        issue_wb_en;
   logic [3:0]  issue_dest;
   logic        wb_en;
   logic [3:0]  wb_dest;
   logic        hazard_detected;
   logic        issue_fire;
   logic [15:0] busy;
   logic        wb_underflow;

   modport master (
      output src1, src2, two_src, issue_valid, issue_wb_en, issue_dest, wb_en, wb_dest,
      input  hazard_detected, issue_fire, busy, wb_underflow
   );

   modport slave (
      input  src1, src2, two_src, issue_valid, issue_wb_en, issue_dest, wb_en, wb_dest,
      output hazard_detected, issue_fire, busy, wb_underflow
   );
endinterface

// File: rtl/reg_scoreboard.sv
// Register-pending scoreboard: counts outstanding writes per register, stalls ID
// on RAW hazards and on saturated counters, and flags commits with nothing pending.
module reg_scoreboard #(
   parameter int unsigned MAX_PEND = 3
) (
   input  logic             clk,
   input  logic             rst,
   reg_scoreboard_if.slave  bus
);
   localparam int unsigned         CntW   = $clog2(MAX_PEND + 1);
   localparam logic [CntW-1:0]     CntMax = CntW'(MAX_PEND);
   localparam logic [CntW-1:0]     CntOne = CntW'(1);

   logic [CntW-1:0] r_cnt   [16];
   logic [CntW-1:0] w_cnt_d [16];
   logic            r_underflow;
   logic            w_underflow_d;
   logic            w_hazard;
   logic            w_fire;
   logic [15:0]     w_inc;
   logic [15:0]     w_dec;
   logic [15:0]     w_busy;

   // Registered counts only: a same-cycle commit does not release the stall.
   always_comb begin
      w_hazard = (r_cnt[bus.src1] != '0)
               | (bus.two_src & (r_cnt[bus.src2] != '0))
               | (bus.issue_valid & bus.issue_wb_en & (r_cnt[bus.issue_dest] == CntMax));
      w_fire   = bus.issue_valid & ~w_hazard;
   end

   always_comb begin
      w_underflow_d = r_underflow | (bus.wb_en & (r_cnt[bus.wb_dest] == '0));
      w_inc         = '0;
      w_dec         = '0;
      w_busy        = '0;
      for (int i = 0; i < 16; i++) begin
         w_inc[i]   = w_fire & bus.issue_wb_en & (bus.issue_dest == 4'(i));
         w_dec[i]   = bus.wb_en & (bus.wb_dest == 4'(i)) & (r_cnt[i] != '0);
         w_cnt_d[i] = r_cnt[i];
         if (w_inc[i] && !w_dec[i]) begin
            w_cnt_d[i] = r_cnt[i] + CntOne;
         end else if (w_dec[i] && !w_inc[i]) begin
            w_cnt_d[i] = r_cnt[i] - CntOne;
         end
         w_busy[i]  = |r_cnt[i];
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 16; i++) begin
            r_cnt[i] <= '0;
         end
         r_underflow <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_d;
         r_underflow <= w_underflow_d;
      end
   end

   assign bus.hazard_detected = w_hazard;
   assign bus.issue_fire      = w_fire;
   assign bus.busy            = w_busy;
   assign bus.wb_underflow    = r_underflow;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Bench for reg_scoreboard: directed vector table for the pipeline corner cases,
// then randomized traffic against a per-register pending-count model.
module tb_reg_scoreboard;
   localparam int unsigned MAX_PEND = 3;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   reg_scoreboard_if bus ();

   reg_scoreboard #(.MAX_PEND(MAX_PEND)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [3:0]  src1;
      logic [3:0]  src2;
      logic        two_src;
      logic        iv;
      logic        iwe;
      logic [3:0]  idest;
      logic        wbe;
      logic [3:0]  wbd;
      logic        haz;
      logic        fire;
      logic [15:0] busy;
      logic        uf;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;
   int   m_cnt[16];
   bit   m_uf;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                      input logic iv, input logic iwe, input logic [3:0] idest,
                      input logic wbe, input logic [3:0] wbd, input logic haz,
                      input logic fire, input logic [15:0] busy, input logic uf);
      vec_t v;
      v.src1 = s1; v.src2 = s2; v.two_src = two; v.iv = iv; v.iwe = iwe; v.idest = idest;
      v.wbe = wbe; v.wbd = wbd; v.haz = haz; v.fire = fire; v.busy = busy; v.uf = uf;
      tbl.push_back(v);
   endtask

   task automatic drive(input logic [3:0] s1, input logic [3:0] s2, input logic two,
                        input logic iv, input logic iwe, input logic [3:0] idest,
                        input logic wbe, input logic [3:0] wbd);
      bus.src1 = s1; bus.src2 = s2; bus.two_src = two; bus.issue_valid = iv;
      bus.issue_wb_en = iwe; bus.issue_dest = idest; bus.wb_en = wbe; bus.wb_dest = wbd;
   endtask

   function automatic logic model_haz();
      return (m_cnt[bus.src1] != 0) || (bus.two_src && m_cnt[bus.src2] != 0) ||
             (bus.issue_valid && bus.issue_wb_en && m_cnt[bus.issue_dest] == MAX_PEND);
   endfunction

   function automatic logic [15:0] model_busy();
      logic [15:0] b;
      for (int i = 0; i < 16; i++) b[i] = (m_cnt[i] != 0);
      return b;
   endfunction

   task automatic model_step();
      logic fire;
      int   nxt[16];
      fire = bus.issue_valid && !model_haz();
      if (bus.wb_en && m_cnt[bus.wb_dest] == 0) m_uf = 1'b1;
      for (int i = 0; i < 16; i++) begin
         nxt[i] = m_cnt[i];
         if (fire && bus.issue_wb_en && bus.issue_dest == 4'(i)) nxt[i] = nxt[i] + 1;
         if (bus.wb_en && bus.wb_dest == 4'(i) && m_cnt[i] != 0) nxt[i] = nxt[i] - 1;
      end
      m_cnt = nxt;
   endtask

   task automatic model_reset();
      for (int i = 0; i < 16; i++) m_cnt[i] = 0;
      m_uf = 1'b0;
   endtask

   task automatic reset_phase(input string tag);
      rst = 1'b0;
      drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b0, 1'($urandom), 4'($urandom),
            1'($urandom), 4'($urandom));
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'h0);
      check({tag, "_uf"}, 32'(bus.wb_underflow), 32'h0);
      check({tag, "_haz"}, 32'(bus.hazard_detected), 32'h0);
      check({tag, "_fire"}, 32'(bus.issue_fire), 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   initial begin
      // Load-use on R3, commit in the last stalled cycle.
      add(0, 0, 0, 1, 1, 3, 0, 0, 0, 1, 16'h0000, 0);
      add(3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0008, 0);
      add(3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0008, 0);
      add(3, 0, 0, 1, 0, 0, 0, 0, 1, 0, 16'h0008, 0);
      add(3, 0, 0, 1, 0, 0, 1, 3, 1, 0, 16'h0008, 0);
      add(3, 0, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0000, 0);
      // two_src gating on R7.
      add(0, 0, 0, 1, 1, 7, 0, 0, 0, 1, 16'h0000, 0);
      add(2, 7, 1, 1, 0, 0, 0, 0, 1, 0, 16'h0080, 0);
      add(2, 7, 0, 1, 0, 0, 0, 0, 0, 1, 16'h0080, 0);
      add(0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 16'h0080, 0);
      // Simultaneous issue and commit on R5.
      add(0, 0, 0, 1, 1, 5, 0, 0, 0, 1, 16'h0000, 0);
      add(0, 0, 0, 1, 1, 5, 1, 5, 0, 1, 16'h0020, 0);
      add(0, 0, 0, 0, 0, 0, 1, 5, 0, 0, 16'h0020, 0);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 0);
      // Saturation on R9.
      add(0, 0, 0, 1, 1, 9, 0, 0, 0, 1, 16'h0000, 0);
      add(0, 0, 0, 1, 1, 9, 0, 0, 0, 1, 16'h0200, 0);
      add(0, 0, 0, 1, 1, 9, 0, 0, 0, 1, 16'h0200, 0);
      add(0, 0, 0, 1, 1, 9, 0, 0, 1, 0, 16'h0200, 0);
      add(0, 0, 0, 1, 1, 9, 1, 9, 1, 0, 16'h0200, 0);
      add(0, 0, 0, 1, 1, 9, 0, 0, 0, 1, 16'h0200, 0);
      add(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 16'h0200, 0);
      add(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 16'h0200, 0);
      add(0, 0, 0, 0, 0, 0, 1, 9, 0, 0, 16'h0200, 0);
      // Underflow on R4, then sticky across traffic.
      add(0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 16'h0000, 0);
      add(0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 16'h0000, 1);
      add(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 16'h0002, 1);
      add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 16'h0000, 1);

      reset_phase("reset0");

      for (int k = 0; k < tbl.size(); k++) begin
         drive(tbl[k].src1, tbl[k].src2, tbl[k].two_src, tbl[k].iv, tbl[k].iwe,
               tbl[k].idest, tbl[k].wbe, tbl[k].wbd);
         @(negedge clk);
         check($sformatf("vec%0d_haz", k), 32'(bus.hazard_detected), 32'(tbl[k].haz));
         check($sformatf("vec%0d_fire", k), 32'(bus.issue_fire), 32'(tbl[k].fire));
         check($sformatf("vec%0d_busy", k), 32'(bus.busy), 32'(tbl[k].busy));
         check($sformatf("vec%0d_uf", k), 32'(bus.wb_underflow), 32'(tbl[k].uf));
         @(posedge clk);
         #1;
      end

      // Mid-operation reset with R2 pending and the underflow flag set.
      drive(0, 0, 0, 1, 1, 2, 0, 0);
      @(posedge clk);
      #1;
      drive(2, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      check("pre_rst_busy", 32'(bus.busy), 32'h0004);
      check("pre_rst_uf", 32'(bus.wb_underflow), 32'h1);
      reset_phase("reset_mid");

      // Randomized traffic against the model.
      for (int k = 0; k < 400; k++) begin
         drive(4'($urandom_range(0, 5)), 4'($urandom_range(0, 5)), 1'($urandom),
               1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 3) != 0),
               4'($urandom_range(0, 5)), 1'($urandom_range(0, 2) == 0),
               4'($urandom_range(0, 5)));
         @(negedge clk);
         check("rnd_haz", 32'(bus.hazard_detected), 32'(model_haz()));
         check("rnd_fire", 32'(bus.issue_fire), 32'(bus.issue_valid && !model_haz()));
         check("rnd_busy", 32'(bus.busy), 32'(model_busy()));
         check("rnd_uf", 32'(bus.wb_underflow), 32'(m_uf));
         model_step();
         @(posedge clk);
         #1;
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Register-pending scoreboard for the 5-stage ARM pipeline: the write-side counterpart of ID-stage hazard checking. It records every destination register an issued instruction will write and retires it when the write-back stage commits it. ID-stage source operands are checked against this record, so the block stalls correctly for any write-back latency, including multi-cycle SRAM loads. It sits beside the ID stage, is fed by the ID→EXE issue point and the WB stage, and drives the pipeline freeze.

## Interface
Parameters:
- MAX_PEND, 3: maximum outstanding writes per register; counter width is clog2(MAX_PEND+1).

Ports:
- clk  input  1  pipeline clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- src1  input  4  ID-stage first source register index.
- src2  input  4  ID-stage second source register index.
- two_src  input  1  src2 is a real operand.
- issue_valid  input  1  ID has an instruction ready to advance to EXE.
- issue_wb_en  input  1  that instruction writes a register.
- issue_dest  input  4  its destination index.
- wb_en  input  1  WB stage commits a register write this cycle.
- wb_dest  input  4  index being committed.
- hazard_detected  output  1  ID must stall (combinational from registered state and ID inputs).
- issue_fire  output  1  issue accepted this cycle.
- busy  output  16  bit i set when the pending count of register i is non-zero (registered).
- wb_underflow  output  1  sticky error: a commit arrived for a register with count 0.

## Operation
- State: 16 pending counters, cnt[0..15], plus the wb_underflow flag.
- hazard_detected = (cnt[src1]≠0) | (two_src & cnt[src2]≠0) | (issue_valid & issue_wb_en & cnt[issue_dest]==MAX_PEND).
- The hazard check uses registered counts only. There is no same-cycle bypass from wb_en.
- issue_fire = issue_valid & ~hazard_detected.
- Per-register update, evaluated independently for each i:
  - inc = issue_fire & issue_wb_en & issue_dest==i
  - dec = wb_en & wb_dest==i & cnt[i]≠0
  - inc & ~dec: cnt[i]+1. dec & ~inc: cnt[i]−1. Both or neither: unchanged.
- Commit to a register with cnt==0: counters unchanged, wb_underflow set to 1. It stays set until reset.
- Counters never wrap. Issue to a saturated register is blocked by the hazard term, so an increment past MAX_PEND cannot occur.
- busy[i] = |cnt[i]. It reflects post-edge state.

## Timing
- Reset (rst low, asynchronous): all cnt=0, busy=0, wb_underflow=0. With issue_valid=0, hazard_detected=0 and issue_fire=0.
- Reset deasserts synchronously to clk (external synchronizer). The first update occurs on the first rising edge with rst high.
- Issue at edge N: busy[dest]=1 and hazard visible to ID from cycle N+1.
- Commit at edge M: the counter decrements at M. A stalled dependent sees hazard_detected=0 in cycle M+1 and fires then, giving a minimum one-cycle stall after the commit cycle.
- Reset mid-operation clears all pending state. In-flight pipeline instructions must be flushed by the same reset.
- hazard_detected has no path from wb_en/wb_dest. issue_fire depends combinationally on issue_valid, src1, src2, two_src, issue_wb_en and issue_dest.

## Test plan
- Reset: hold rst=0 with random inputs → busy=0, wb_underflow=0. With issue_valid=0, hazard_detected=0.
- Load-use: issue dest=R3 at cycle 1, then src1=R3 in cycles 2–5, then wb_en with wb_dest=3 at cycle 5 → hazard_detected=1 in cycles 2–5, then 0 and issue_fire=1 in cycle 6. busy[3] reads 1 after the edge ending cycle 1 and 0 after the edge ending cycle 5.
- two_src gating: R7 pending, src2=7 → hazard only when two_src=1. With two_src=0, src1=2 → issue_fire=1.
- Simultaneous: cnt[5]=1, same-cycle issue dest=5 and commit wb_dest=5 → cnt[5] stays 1 and busy[5] stays 1. A following commit makes busy[5]=0.
- Saturation: three issues to R9 without commits (MAX_PEND=3) → a fourth issue_valid with dest=9 gives hazard_detected=1 and issue_fire=0. One commit to R9 → the fourth issue fires the next cycle.
- Underflow: commit wb_dest=4 with cnt[4]=0 → wb_underflow=1, no counter changes. The flag stays 1 across further traffic until rst=0.
